// File: rtl/html_char_stream.sv
// Purpose : character FIFO between the HTML source and the tokenizer, with one-char lookahead,
//           optional CR stripping, head line/column tracking and end-of-document detection.
// Latency : 1 cycle push-to-head on an empty buffer; 1 char/cycle sustained.
// Backpr. : in_ready = run && not full && no in_last seen yet; it never depends on out_ready.
//
// Ports:
//   clock, state_enable         clock and synchronous active-low reset (0 = reset)
//   in_char/in_valid/in_last    producer side, handshake with in_ready
//   out_char/out_valid/out_last consumer side head entry, popped when out_ready
//   peek_char/peek_valid        entry behind the head
//   line/column                 1-based position of the head character
//   count                       stored entries
//   has_finished                final character consumed and buffer empty
module html_char_stream #(
   parameter int CHAR_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int LINE_WIDTH = 16,
   parameter int COL_WIDTH  = 12,
   parameter bit STRIP_CR   = 1'b1
) (
   input  logic                           clock,
   input  logic                           state_enable,
   input  logic [CHAR_WIDTH-1:0]          in_char,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [CHAR_WIDTH-1:0]          out_char,
   output logic                           out_valid,
   output logic                           out_last,
   input  logic                           out_ready,
   output logic [CHAR_WIDTH-1:0]          peek_char,
   output logic                           peek_valid,
   output logic [LINE_WIDTH-1:0]          line,
   output logic [COL_WIDTH-1:0]           column,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           has_finished
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [CHAR_WIDTH-1:0] CH_CR   = CHAR_WIDTH'(8'h0D);
   localparam logic [CHAR_WIDTH-1:0] CH_LF   = CHAR_WIDTH'(8'h0A);
   localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic                  last;
      logic [CHAR_WIDTH-1:0] chr;
   } entry_t;

   entry_t                mem_q [DEPTH];
   entry_t                mem_d [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  eos_q, eos_d;
   // run_q is low for the cycle following a reset edge so in_ready stays
   // low during that cycle, then rises for good.
   logic                  run_q, run_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic [COL_WIDTH-1:0]  col_q, col_d;

   logic                  not_empty;
   logic                  two_plus;
   logic                  push;
   logic                  pop;
   logic                  store;
   logic                  is_cr;
   logic [PTR_W-1:0]      rd_ptr_inc;
   entry_t                head;
   entry_t                behind;

   // Status decode, all from registers
   always_comb begin
      not_empty  = (count_q != '0);
      two_plus   = (count_q >= CNT_W'(2));
      rd_ptr_inc = rd_ptr_q + PTR_W'(1);
      head       = mem_q[rd_ptr_q];
      behind     = mem_q[rd_ptr_inc];
      in_ready   = run_q && (count_q < DEPTH_C) && !eos_q;
      push       = in_valid && in_ready;
      pop        = not_empty && out_ready;
      // A stripped CR is still a handshake (and may carry in_last) but takes no slot
      is_cr      = STRIP_CR && (in_char == CH_CR);
      store      = push && !is_cr;
   end

   // Next-state logic
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      eos_d    = eos_q;
      run_d    = 1'b1;
      line_d   = line_q;
      col_d    = col_q;

      if (store) begin
         mem_d[wr_ptr_q] = '{last: in_last, chr: in_char};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_inc;
      end

      unique case ({store, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (push && in_last) begin
         eos_d = 1'b1;
      end

      // Position advances past the character being consumed
      if (pop) begin
         if (head.chr == CH_LF) begin
            line_d = (line_q == '1) ? line_q : line_q + LINE_WIDTH'(1);
            col_d  = COL_WIDTH'(1);
         end else begin
            col_d  = (col_q == '1) ? col_q : col_q + COL_WIDTH'(1);
         end
      end
   end

   // Control and position registers
   always_ff @(posedge clock) begin
      if (!state_enable) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         eos_q    <= 1'b0;
         run_q    <= 1'b0;
         line_q   <= LINE_WIDTH'(1);
         col_q    <= COL_WIDTH'(1);
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         eos_q    <= eos_d;
         run_q    <= run_d;
         line_q   <= line_d;
         col_q    <= col_d;
      end
   end

   // Storage needs no reset: count_q gates every read
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   // Outputs
   always_comb begin
      out_valid    = not_empty;
      out_char     = not_empty ? head.chr  : '0;
      out_last     = not_empty ? head.last : 1'b0;
      peek_valid   = two_plus;
      peek_char    = two_plus ? behind.chr : '0;
      line         = line_q;
      column       = col_q;
      count        = count_q;
      has_finished = eos_q && !not_empty;
   end

endmodule

// File: tb/tb_html_char_stream.sv
module tb_html_char_stream;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       state_enable;
   logic [7:0] in_char;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] out_char;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic [7:0] peek_char;
   logic       peek_valid;
   logic [15:0] line;
   logic [11:0] column;
   logic [4:0] count;
   logic       has_finished;

   always #5 clock = ~clock;

   html_char_stream #(
      .CHAR_WIDTH(8), .DEPTH(DEPTH), .LINE_WIDTH(16), .COL_WIDTH(12), .STRIP_CR(1'b1)
   ) dut (
      .clock(clock), .state_enable(state_enable),
      .in_char(in_char), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_char(out_char), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .peek_char(peek_char), .peek_valid(peek_valid),
      .line(line), .column(column), .count(count), .has_finished(has_finished)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of {last, char} plus document position
   logic [8:0] q[$];
   bit         m_eos;
   bit         m_run;
   int         m_line;
   int         m_col;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int n;
      n = q.size();
      chk("in_ready",     32'(in_ready),     32'(m_run && n < DEPTH && !m_eos));
      chk("out_valid",    32'(out_valid),    32'(n >= 1));
      chk("out_char",     32'(out_char),     (n >= 1) ? 32'(q[0][7:0]) : 32'd0);
      chk("out_last",     32'(out_last),     (n >= 1) ? 32'(q[0][8])   : 32'd0);
      chk("peek_valid",   32'(peek_valid),   32'(n >= 2));
      chk("peek_char",    32'(peek_char),    (n >= 2) ? 32'(q[1][7:0]) : 32'd0);
      chk("count",        32'(count),        32'(n));
      chk("line",         32'(line),         32'(m_line));
      chk("column",       32'(column),       32'(m_col));
      chk("has_finished", 32'(has_finished), 32'(m_eos && n == 0));
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge
   task automatic step(input bit en, input bit vld, input logic [7:0] ch,
                       input bit last, input bit rdy);
      bit         rdy_in;
      logic [8:0] e;
      state_enable = en;
      in_valid     = vld;
      in_char      = ch;
      in_last      = last;
      out_ready    = rdy;
      rdy_in = m_run && q.size() < DEPTH && !m_eos;
      if (!en) begin
         q.delete();
         m_eos = 0; m_run = 0; m_line = 1; m_col = 1;
      end else begin
         if (q.size() > 0 && rdy) begin
            e = q.pop_front();
            if (e[7:0] == 8'h0A) begin
               if (m_line < 65535) m_line++;
               m_col = 1;
            end else if (m_col < 4095) begin
               m_col++;
            end
         end
         if (vld && rdy_in) begin
            if (ch != 8'h0D) q.push_back({last, ch});
            if (last) m_eos = 1;
         end
         m_run = 1;
      end
      @(posedge clock);
      @(negedge clock);
      check_model();
   endtask

   typedef struct {
      bit en; bit vld; logic [7:0] ch; bit last; bit rdy;
      bit ov; logic [7:0] oc; bit ol; bit pv; logic [7:0] pc;
      int ln; int cl; int cnt; bit ir; bit fin;
   } vec_t;

   function automatic vec_t v(bit en, bit vld, logic [7:0] ch, bit last, bit rdy,
                              bit ov, logic [7:0] oc, bit ol, bit pv, logic [7:0] pc,
                              int ln, int cl, int cnt, bit ir, bit fin);
      vec_t r;
      r.en = en; r.vld = vld; r.ch = ch; r.last = last; r.rdy = rdy;
      r.ov = ov; r.oc = oc; r.ol = ol; r.pv = pv; r.pc = pc;
      r.ln = ln; r.cl = cl; r.cnt = cnt; r.ir = ir; r.fin = fin;
      return r;
   endfunction

   vec_t tbl[20];

   initial begin
      //            en vld ch     lst rdy   ov oc     ol pv pc     ln cl cnt ir fin
      tbl[0]  = v(0, 0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0);
      tbl[1]  = v(1, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1, 0);
      tbl[2]  = v(1, 1, 8'h61, 0, 1,    1, 8'h61, 0, 0, 8'h00, 1, 1, 1, 1, 0);
      tbl[3]  = v(1, 1, 8'h62, 1, 1,    1, 8'h62, 1, 0, 8'h00, 1, 2, 1, 0, 0);
      tbl[4]  = v(1, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0, 1);
      tbl[5]  = v(1, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0, 1);
      tbl[6]  = v(0, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0);
      tbl[7]  = v(1, 1, 8'h78, 0, 0,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1, 0);
      tbl[8]  = v(1, 1, 8'h78, 0, 1,    1, 8'h78, 0, 0, 8'h00, 1, 1, 1, 1, 0);
      tbl[9]  = v(1, 1, 8'h0D, 0, 1,    0, 8'h00, 0, 0, 8'h00, 1, 2, 0, 1, 0);
      tbl[10] = v(1, 1, 8'h0A, 0, 1,    1, 8'h0A, 0, 0, 8'h00, 1, 2, 1, 1, 0);
      tbl[11] = v(1, 1, 8'h79, 1, 1,    1, 8'h79, 1, 0, 8'h00, 2, 1, 1, 0, 0);
      tbl[12] = v(1, 0, 8'h00, 0, 1,    0, 8'h00, 0, 0, 8'h00, 2, 2, 0, 0, 1);
      tbl[13] = v(0, 0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0);
      tbl[14] = v(1, 0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1, 0);
      tbl[15] = v(1, 1, 8'h3C, 0, 0,    1, 8'h3C, 0, 0, 8'h00, 1, 1, 1, 1, 0);
      tbl[16] = v(1, 1, 8'h2F, 0, 0,    1, 8'h3C, 0, 1, 8'h2F, 1, 1, 2, 1, 0);
      tbl[17] = v(1, 0, 8'h00, 0, 1,    1, 8'h2F, 0, 0, 8'h00, 1, 2, 1, 1, 0);
      tbl[18] = v(1, 1, 8'h0D, 1, 1,    0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0, 1);
      tbl[19] = v(0, 0, 8'h00, 0, 0,    0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0);

      state_enable = 0; in_valid = 0; in_char = 0; in_last = 0; out_ready = 0;
      m_eos = 0; m_run = 0; m_line = 1; m_col = 1;

      // Directed vectors
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].en, tbl[i].vld, tbl[i].ch, tbl[i].last, tbl[i].rdy);
         chk($sformatf("tbl%0d.out_valid", i),  32'(out_valid),    32'(tbl[i].ov));
         chk($sformatf("tbl%0d.out_char", i),   32'(out_char),     32'(tbl[i].oc));
         chk($sformatf("tbl%0d.out_last", i),   32'(out_last),     32'(tbl[i].ol));
         chk($sformatf("tbl%0d.peek_valid", i), 32'(peek_valid),   32'(tbl[i].pv));
         chk($sformatf("tbl%0d.peek_char", i),  32'(peek_char),    32'(tbl[i].pc));
         chk($sformatf("tbl%0d.line", i),       32'(line),         32'(tbl[i].ln));
         chk($sformatf("tbl%0d.column", i),     32'(column),       32'(tbl[i].cl));
         chk($sformatf("tbl%0d.count", i),      32'(count),        32'(tbl[i].cnt));
         chk($sformatf("tbl%0d.in_ready", i),   32'(in_ready),     32'(tbl[i].ir));
         chk($sformatf("tbl%0d.has_finished", i), 32'(has_finished), 32'(tbl[i].fin));
      end

      // Fill to full, then pop-while-full, then drain across the pointer wrap
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(8'h30 + i), 0, 0);
      chk("full.count", 32'(count), 32'd16);
      chk("full.in_ready", 32'(in_ready), 32'd0);
      step(1, 1, 8'h40, 0, 1);
      chk("full_pop.count", 32'(count), 32'd15);
      chk("full_pop.in_ready", 32'(in_ready), 32'd1);
      step(1, 1, 8'h40, 0, 0);
      chk("refill.count", 32'(count), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("drain%0d.out_char", i), 32'(out_char), 32'(8'h31 + i));
         step(1, 0, 8'h00, 0, 1);
      end
      chk("drained.count", 32'(count), 32'd0);

      // Mid-stream reset with 5 entries stored
      for (int i = 0; i < 7; i++) step(1, 1, (i == 1) ? 8'h0A : 8'(8'h61 + i), 0, 0);
      step(1, 0, 8'h00, 0, 1);
      step(1, 0, 8'h00, 0, 1);
      chk("mid.count", 32'(count), 32'd5);
      chk("mid.line", 32'(line), 32'd2);
      step(0, 1, 8'h7A, 0, 1);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.line", 32'(line), 32'd1);
      chk("rst.column", 32'(column), 32'd1);
      chk("rst.has_finished", 32'(has_finished), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      step(1, 0, 8'h00, 0, 0);
      chk("post_rst.in_ready", 32'(in_ready), 32'd1);
      step(1, 1, 8'h6B, 0, 0);
      chk("post_rst.out_char", 32'(out_char), 32'h6B);
      chk("post_rst.count", 32'(count), 32'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit         en, vld, last, rdy;
         logic [7:0] ch;
         int         sel;
         en   = ($urandom_range(0, 199) != 0);
         if (m_eos && q.size() == 0 && $urandom_range(0, 7) == 0) en = 0;
         vld  = ($urandom_range(0, 3) != 0);
         sel  = $urandom_range(0, 9);
         ch   = (sel == 0) ? 8'h0D : (sel == 1) ? 8'h0A : 8'($urandom_range(0, 255));
         last = ($urandom_range(0, 79) == 0);
         rdy  = (((i / 400) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 5) == 0);
         step(en, vld, ch, last, rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/html_char_stream.md
# html_char_stream

Parametrised, synthesizable character-stream buffer between the HTML source (file reader or external loader) and the tokenizer. It buffers up to DEPTH characters with valid/ready handshakes on both sides and exposes a one-character lookahead. It optionally strips carriage returns, tracks the line/column of the head character, and raises `has_finished` once the final character has been consumed.

## Interface
Parameters:
- CHAR_WIDTH, 8, character width in bits
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- LINE_WIDTH, 16, line counter width
- COL_WIDTH, 12, column counter width
- STRIP_CR, 1, when 1, characters equal to 8'h0D are accepted but not stored

Ports:
- clock  in  1  single clock; all logic on posedge
- state_enable  in  1  synchronous active-low reset: 0 = reset (sampled on posedge clock), 1 = run
- in_char  in  CHAR_WIDTH  incoming character
- in_valid  in  1  in_char is valid
- in_last  in  1  in_char is the final character of the document
- in_ready  out  1  buffer can accept a character this cycle
- out_char  out  CHAR_WIDTH  head character
- out_valid  out  1  out_char is valid
- out_last  out  1  head character carried in_last
- out_ready  in  1  consumer takes the head this cycle
- peek_char  out  CHAR_WIDTH  character after the head
- peek_valid  out  1  peek_char is valid
- line  out  LINE_WIDTH  line number of the head character, 1-based
- column  out  COL_WIDTH  column of the head character, 1-based
- count  out  clog2(DEPTH+1)  stored entries
- has_finished  out  1  last character consumed; buffer empty

## Operation
- Storage: circular FIFO of {last, char} entries, with read and write pointers of clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Push: occurs when in_valid && in_ready.
  - If STRIP_CR=1 and in_char==8'h0D, the character is consumed and nothing is stored.
  - Otherwise the entry is written at the write pointer and the pointer advances.
- in_ready = (count < DEPTH) && !eos_seen. It does not depend on out_ready, so there is no combinational path from the output side.
- eos_seen: set on any push with in_last=1, including a stripped CR. It stays set until reset. After that, in_ready=0.
- Pop: occurs when out_valid && out_ready. The read pointer advances.
- out_valid = count≥1. out_char/out_last = entry[rd]. Outputs are 0 when empty.
- peek_valid = count≥2. peek_char = entry[rd+1 mod DEPTH], or 0 when not valid.
- Simultaneous push and pop: count is unchanged and both pointers advance. At count==DEPTH, no push occurs even if a pop occurs.
- Position tracking, on each pop:
  - Popped char 8'h0A: line ← line+1 (saturating at all-ones), column ← 1.
  - Otherwise: column ← column+1 (saturating at all-ones).
- has_finished = eos_seen && count==0. It stays high until reset.
- Reset (state_enable=0 at posedge), which also applies mid-stream:
  - pointers, count, eos_seen ← 0; line, column ← 1.
  - All outputs take their reset values on the next cycle: in_ready=0 during the reset cycle and 1 afterwards; out_valid=0, out_char=0, out_last=0, peek_valid=0, peek_char=0, count=0, has_finished=0.
  - Stored contents are discarded.

## Timing
- Push-to-out latency: 1 cycle. A character pushed at edge N is visible on out_char after edge N (empty buffer).
- Pop is effective at the clock edge. The next head appears in the same cycle the line/column update is visible.
- Steady state with in_valid=out_ready=1: 1 character per cycle.
- has_finished rises in the cycle after the edge that pops the last entry. If the last character is a stripped CR and the buffer is already empty, it rises after that push edge.
- All outputs are functions of registers only.

## Test plan
- Reset then push "ab" with in_last on 'b', out_ready=1:
  - 'a' appears 1 cycle after its push, with line=1, column=1.
  - 'b' appears with out_last=1 and column=2.
  - has_finished=1 one cycle after 'b' pops; in_ready=0 from then on.
- Fill with out_ready=0: after 16 pushes, count=16 and in_ready=0. One pop then lets exactly one more push in, and the pointers wrap correctly (data order preserved).
- Stream "x\r\ny" with STRIP_CR=1:
  - Output sequence is 'x', 8'h0A, 'y'.
  - At 'y', line=2 and column=1; 'x' showed column=1.
- Lookahead: push "</" with out_ready=0 → out_char='<', peek_char='/', peek_valid=1. After one pop, peek_valid=0.
- Full buffer with simultaneous in_valid=1 and out_ready=1: no push occurs, count decrements to 15, and the next cycle accepts the push.
- Reset mid-stream with 5 entries stored:
  - Next cycle: count=0, out_valid=0, line=1, column=1, has_finished=0.
  - The cycle after, in_ready=1 and a fresh push works.
